nios2_jtag_debug_host_master: RTL and testbench

//  Host-side JTAG scan engine: the initiating end of the Nios II JTAG debug link.

---
 rtl/nios2_jtag_debug_host_master.sv | 163 ++++++++++++++++
 tb/tb_nios2_jtag_debug_host_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_jtag_debug_host_master.sv
// Host-side JTAG scan engine: turns IR/DR scan commands into TCK/TMS/TDI waveforms
// and returns the TDO bits captured during the shift phase.
//
// state   | meaning
// TAP_RST | 6 TCK cycles of TMS 1,1,1,1,1,0 to park the target TAP in Run-Test/Idle
// IDLE    | TAP in Run-Test/Idle, tck held low, ready for a command
// SCAN    | walking the TAP through an IR or DR scan, shifting cmd_data out
// DONE    | one-cycle response pulse for a completed scan
// ERR     | illegal length accepted; no TCK activity, error response follows
module nios2_jtag_debug_host_master #(
  parameter int TCK_DIV = 2,
  parameter int MAX_LEN = 38,
  parameter int LEN_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  input  logic               tap_reset_req,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int HP_W  = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int CYC_W = $clog2(MAX_LEN + 7);
  localparam logic [HP_W-1:0] HP_LOAD = HP_W'(TCK_DIV - 1);

  typedef enum logic [2:0] {S_TAP_RST, S_IDLE, S_SCAN, S_DONE, S_ERR} state_t;

  state_t             state, state_nxt;
  logic [HP_W-1:0]    hp_cnt;
  logic [CYC_W-1:0]   cyc;
  logic               is_ir_q;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-1:0] data_q, cap;

  logic in_seq, hp_tc, last_cyc, shifting, accept, len_ok, seq_end, rsp_fire;
  int   n_cyc, pre, sidx;

  // TMS for TCK cycle k; the shift phase starts at k == pre (3 for DR, 4 for IR)
  function automatic logic tms_at(input logic rst_seq, input logic ir, input int len,
                                  input int k);
    int p;
    p = ir ? 4 : 3;
    if (rst_seq) return (k < 5);
    if (k == 0 || (ir && k == 1)) return 1'b1;
    if (k < p) return 1'b0;
    if (k < p + len) return (k == p + len - 1);
    return (k == p + len);
  endfunction

  function automatic logic tdi_at(input logic ir, input int len,
                                  input logic [MAX_LEN-1:0] data, input int k);
    int s;
    s = k - (ir ? 4 : 3);
    if (s >= 0 && s < len) return 1'(data >> s);
    return 1'b0;
  endfunction

  always_comb begin
    in_seq    = (state == S_TAP_RST) || (state == S_SCAN);
    hp_tc     = (hp_cnt == '0);
    pre       = is_ir_q ? 4 : 3;
    n_cyc     = (state == S_TAP_RST) ? 6 : int'(len_q) + pre + 2;
    last_cyc  = (int'(cyc) == n_cyc - 1);
    sidx      = int'(cyc) - pre;
    shifting  = (state == S_SCAN) && (sidx >= 0) && (sidx < int'(len_q));
    len_ok    = (cmd_len != '0) && (int'(cmd_len) <= MAX_LEN);
    cmd_ready = (state == S_IDLE) && !tap_reset_req;
    busy      = !cmd_ready;
    accept    = cmd_valid && cmd_ready;
    seq_end   = in_seq && hp_tc && tck && last_cyc;
    rsp_fire  = ((state == S_SCAN) && seq_end) || (state == S_ERR);
    state_nxt = state;
    case (state)
      S_TAP_RST: if (seq_end) state_nxt = S_IDLE;
      S_IDLE: begin
        if (tap_reset_req)  state_nxt = S_TAP_RST;
        else if (cmd_valid) state_nxt = len_ok ? S_SCAN : S_ERR;
      end
      S_SCAN:  if (seq_end) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_TAP_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_TAP_RST;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hp_cnt    <= HP_LOAD;
      cyc       <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      is_ir_q   <= 1'b0;
      len_q     <= '0;
      data_q    <= '0;
      cap       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        rsp_data <= (state == S_ERR) ? '0 : cap;
        rsp_err  <= (state == S_ERR);
      end
      if (accept) begin
        is_ir_q <= cmd_is_ir;
        len_q   <= cmd_len;
        data_q  <= cmd_data;
        cap     <= '0;
        cyc     <= '0;
        hp_cnt  <= HP_LOAD;
        tck     <= 1'b0;
        // every scan opens with TMS=1 (to Select-DR); an illegal length leaves pins idle
        tms     <= len_ok;
        tdi     <= 1'b0;
      end else if (state == S_IDLE && tap_reset_req) begin
        cyc    <= '0;
        hp_cnt <= HP_LOAD;
        tck    <= 1'b0;
        tms    <= 1'b1;
        tdi    <= 1'b0;
      end else if (in_seq) begin
        if (hp_tc) begin
          hp_cnt <= HP_LOAD;
          tck    <= ~tck;
          if (!tck && shifting)
            cap <= cap | ({{(MAX_LEN-1){1'b0}}, tdo} << sidx);
          if (tck) begin
            if (last_cyc) begin
              tms <= 1'b0;
              tdi <= 1'b0;
            end else begin
              cyc <= cyc + 1'b1;
              tms <= tms_at(state == S_TAP_RST, is_ir_q, int'(len_q), int'(cyc) + 1);
              tdi <= (state == S_SCAN) ? tdi_at(is_ir_q, int'(len_q), data_q, int'(cyc) + 1)
                                       : 1'b0;
            end
          end
        end else begin
          hp_cnt <= hp_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nios2_jtag_debug_host_master.sv
// Bench for the JTAG host master: a behavioural IEEE 1149.1 TAP target with 38-bit
// IR/DR shift registers, constant vectors, random commands and multi-cycle corner cases.
module tb_nios2_jtag_debug_host_master;
  localparam int TCK_DIV = 2;
  localparam int MAX_LEN = 38;
  localparam int LEN_W   = 6;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_is_ir = 1'b0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               tap_reset_req = 1'b0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic               busy;
  logic               tck, tms, tdi, tdo;

  nios2_jtag_debug_host_master #(.TCK_DIV(TCK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .tap_reset_req(tap_reset_req), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- target TAP model ----------------
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6,
                 EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12,
                 PAIR = 13, EX2IR = 14, UPIR = 15;

  int                 tap_st = TLR;
  logic [MAX_LEN-1:0] sh = '0;
  logic [MAX_LEN-1:0] dr_pre = '0;
  logic [MAX_LEN-1:0] ir_pre = '0;
  logic [MAX_LEN-1:0] upd_val = '0;
  int                 upd_cnt = 0;
  int                 tck_rises = 0;
  logic               tms_log[$];

  assign tdo = sh[0];

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    tms_log.push_back(tms);
    tck_rises++;
    if (tap_st == SHDR || tap_st == SHIR) sh <= {tdi, sh[MAX_LEN-1:1]};
    else if (tap_st == CAPDR)            sh <= dr_pre;
    else if (tap_st == CAPIR)            sh <= ir_pre;
    if (tap_st == UPDR || tap_st == UPIR) begin
      upd_val = sh;
      upd_cnt++;
    end
    tap_st <= tap_next(tap_st, tms);
  end

  function automatic logic [15:0] tms_bits(input int base, input int n);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[14:0], tms_log[base + i]};
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic apply(input string tag, input logic ir, input logic [LEN_W-1:0] len,
                       input logic [MAX_LEN-1:0] data, input logic [MAX_LEN-1:0] pre,
                       input logic exp_err, input logic [MAX_LEN-1:0] exp_rsp,
                       input int exp_lat, input int exp_rises);
    int n, lat, base_r, base_u;
    logic [63:0] m, got;
    if (ir) ir_pre = pre; else dr_pre = pre;
    n = 0;
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    check({tag, " ready"}, cmd_ready, 1);
    base_r = tck_rises;
    base_u = upd_cnt;
    cmd_valid = 1'b1; cmd_is_ir = ir; cmd_len = len; cmd_data = data;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " rsp_err"}, rsp_err, exp_err);
    check({tag, " rsp_data"}, rsp_data, exp_rsp);
    check({tag, " tck_cycles"}, tck_rises - base_r, exp_rises);
    @(negedge clk);
    check({tag, " pulse_len"}, rsp_valid, 0);
    check({tag, " rsp_hold"}, rsp_data, exp_rsp);
    check({tag, " tap_rti"}, tap_st, RTI);
    if (!exp_err) begin
      m = (64'd1 << len) - 64'd1;
      got = 64'(upd_val >> (MAX_LEN - int'(len)));
      check({tag, " updates"}, upd_cnt - base_u, 1);
      check({tag, " tdi_bits"}, got, 64'(data) & m);
    end
  endtask

  // caller releases the sequence start on the preceding edge; this watches 24 edges
  task automatic check_tap_reset(input string tag);
    int base;
    logic saw;
    base = tms_log.size();
    saw = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
      if (k == 23) check({tag, " ready_c24"}, cmd_ready, 0);
      if (k == 24) begin
        check({tag, " ready_c25"}, cmd_ready, 1);
        check({tag, " busy_c25"}, busy, 0);
      end
    end
    check({tag, " no_rsp"}, saw, 0);
    check({tag, " tck_cycles"}, tms_log.size() - base, 6);
    check({tag, " tms_seq"}, (tms_log.size() - base >= 6) ? tms_bits(base, 6) : 16'hFFFF,
          16'b111110);
    check({tag, " tap_rti"}, tap_st, RTI);
  endtask

  typedef struct {
    string              tag;
    logic               ir;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] data;
    logic [MAX_LEN-1:0] pre;
    logic               exp_err;
    logic [MAX_LEN-1:0] exp_rsp;
    int                 exp_lat;
    int                 exp_rises;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int base, n;
    logic ir, legal, saw;
    logic [LEN_W-1:0] len;
    logic [63:0] r1, r2, m;
    logic [MAX_LEN-1:0] data, pre;

    vecs[0] = '{"dr38",  1'b0, 6'd38, 38'h2A_5555_AAAA, 38'h15_0F0F_3C3C, 1'b0, 38'h15_0F0F_3C3C, 172, 43};
    vecs[1] = '{"ir2",   1'b1, 6'd2,  38'h2,            38'h1,            1'b0, 38'h1,            32,  8};
    vecs[2] = '{"len0",  1'b0, 6'd0,  38'h3F_FFFF_FFFF, 38'h3,            1'b1, 38'h0,            1,   0};
    vecs[3] = '{"len39", 1'b0, 6'd39, 38'h12_3456_789A, 38'h3,            1'b1, 38'h0,            1,   0};
    vecs[4] = '{"dr1",   1'b0, 6'd1,  38'h1,            38'h2A_AAAA_AAAB, 1'b0, 38'h1,            24,  6};
    vecs[5] = '{"ir38",  1'b1, 6'd38, 38'h01_8000_0001, 38'h2C_DEAD_BEEF, 1'b0, 38'h2C_DEAD_BEEF, 176, 44};
    vecs[6] = '{"len63", 1'b1, 6'd63, 38'h0,            38'h1,            1'b1, 38'h0,            1,   0};

    // reset values, then automatic TAP reset after release
    repeat (3) @(negedge clk);
    check("rst tck", tck, 0);
    check("rst tms", tms, 1);
    check("rst tdi", tdi, 0);
    check("rst cmd_ready", cmd_ready, 0);
    check("rst busy", busy, 1);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_data", rsp_data, 0);
    check("rst rsp_err", rsp_err, 0);
    reset = 1'b0;
    check_tap_reset("boot");

    foreach (vecs[i])
      apply(vecs[i].tag, vecs[i].ir, vecs[i].len, vecs[i].data, vecs[i].pre,
            vecs[i].exp_err, vecs[i].exp_rsp, vecs[i].exp_lat, vecs[i].exp_rises);

    // IR scan TMS waveform
    base = tms_log.size();
    apply("ir2b", 1'b1, 6'd2, 38'h2, 38'h1, 1'b0, 38'h1, 32, 8);
    check("ir2b tms_seq", (tms_log.size() - base >= 8) ? tms_bits(base, 8) : 16'hFFFF,
          16'b11000110);

    // reset in the middle of shift bit 10 of a DR scan
    n = 0;
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    dr_pre = 38'h0A_5A5A_5A5A;
    base = tck_rises;
    cmd_valid = 1'b1; cmd_is_ir = 1'b0; cmd_len = 6'd38; cmd_data = 38'h3F_0000_FFFF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    saw = 1'b0;
    while (tck_rises - base < 14 && n < 1000) begin
      @(negedge clk);
      n++;
      if (rsp_valid) saw = 1'b1;
    end
    check("abort reach_bit10", tck_rises - base, 14);
    reset = 1'b1;
    @(negedge clk);
    check("abort tck", tck, 0);
    check("abort tms", tms, 1);
    check("abort rsp_valid", rsp_valid | saw, 0);
    @(negedge clk);
    reset = 1'b0;
    check_tap_reset("abort");
    apply("post_abort", 1'b0, 6'd5, 38'h15, 38'h0A, 1'b0, 38'h0A, 40, 10);

    // tap_reset_req wins over a simultaneous command, which is served afterwards
    n = 0;
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    base = tms_log.size();
    cmd_valid = 1'b1; cmd_is_ir = 1'b0; cmd_len = 6'd8; cmd_data = 38'hC3;
    tap_reset_req = 1'b1;
    #1;
    check("req ready_low", cmd_ready, 0);
    @(posedge clk);
    @(negedge clk);
    tap_reset_req = 1'b0;
    check("req busy", busy, 1);
    check_tap_reset("req");
    apply("req_cmd", 1'b0, 6'd8, 38'hC3, 38'h5A, 1'b0, 38'h5A, 52, 13);

    // random commands against the arithmetic model
    for (int t = 0; t < 24; t++) begin
      ir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        len = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(39, 63));
      else
        len = 6'($urandom_range(1, 38));
      r1 = {32'($urandom), 32'($urandom)};
      r2 = {32'($urandom), 32'($urandom)};
      data = r1[MAX_LEN-1:0];
      pre = r2[MAX_LEN-1:0];
      legal = (len >= 1) && (int'(len) <= MAX_LEN);
      m = (64'd1 << len) - 64'd1;
      apply($sformatf("rnd%0d", t), ir, len, data, pre, !legal,
            legal ? MAX_LEN'(64'(pre) & m) : '0,
            legal ? 2 * TCK_DIV * (int'(len) + (ir ? 6 : 5)) : 1,
            legal ? int'(len) + (ir ? 6 : 5) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
